// File: rtl/cart_pkg.sv
// Shared types and constants for the SuperGame cartridge mapper.
// Window bases follow the 7800 cartridge address map ($4000/$8000/$C000).
package cart_pkg;

  typedef enum logic [1:0] {
    MAP_FLAT   = 2'd0,
    MAP_SG     = 2'd1,
    MAP_SG_RAM = 2'd2,
    MAP_RSVD   = 2'd3
  } mapper_e;

  localparam int          BANK_W     = 4;
  localparam logic [15:0] WIN_4000   = 16'h4000;
  localparam logic [15:0] WIN_8000   = 16'h8000;
  localparam logic [15:0] WIN_C000   = 16'hC000;
  localparam logic [15:0] POKEY_SPAN = 16'h0010;

  // Number of 16K banks in the image, capped at what the bank register can address.
  function automatic logic [4:0] calc_bank_count(input logic [31:0] size);
    logic [7:0] banks;
    banks = size[21:14];
    return (banks > 8'd16) ? 5'd16 : banks[4:0];
  endfunction

  function automatic logic [BANK_W-1:0] calc_bank_mask(input logic [4:0] cnt);
    if (cnt <= 5'd1)      return 4'h0;
    else if (cnt <= 5'd2) return 4'h1;
    else if (cnt <= 5'd4) return 4'h3;
    else if (cnt <= 5'd8) return 4'h7;
    else                  return 4'hF;
  endfunction

endpackage

// File: rtl/supergame_mapper_if.sv
// CPU-side cartridge bus as seen by the mapper.
// A bus write is taken on the sampled phi2 falling edge while cart_cs=1, rw=0 and dma_read=0.
interface supergame_mapper_if;
  logic        pclk_2;
  logic [15:0] address_in;
  logic        rw;
  logic [7:0]  din;
  logic        dma_read;
  logic        cart_cs;

  modport master (output pclk_2, address_in, rw, din, dma_read, cart_cs);
  modport slave  (input  pclk_2, address_in, rw, din, dma_read, cart_cs);
endinterface

// File: rtl/sg_bank_reg.sv
// Phi2 edge detect, write commit qualification, SG bank register and cart RAM write strobe.
module sg_bank_reg
  import cart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  supergame_mapper_if.slave bus,
  input  mapper_e           mapper,
  input  logic              pokey_en,
  input  logic [BANK_W-1:0] bank_mask,
  output logic [BANK_W-1:0] bank,
  output logic              ram_we
);

  logic              p2_prev_q, p2_prev_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              ram_we_q, ram_we_d;
  logic              p2_fall, commit, sg_mode;
  logic              in_bank_win, in_ram_win, pokey_hit;
  logic              unused_din;

  assign unused_din = ^bus.din[7:4];

  always_comb begin
    p2_prev_d   = bus.pclk_2;
    p2_fall     = p2_prev_q & ~bus.pclk_2;
    commit      = p2_fall & bus.cart_cs & ~bus.rw & ~bus.dma_read;
    sg_mode     = (mapper == MAP_SG) || (mapper == MAP_SG_RAM);
    in_bank_win = (bus.address_in >= WIN_8000) && (bus.address_in < WIN_C000);
    in_ram_win  = (bus.address_in >= WIN_4000) && (bus.address_in < WIN_8000);
    pokey_hit   = pokey_en && (bus.address_in >= WIN_4000) &&
                  (bus.address_in < (WIN_4000 + POKEY_SPAN));

    bank_d = bank_q;
    if (commit && sg_mode && in_bank_win) begin
      bank_d = bus.din[3:0] & bank_mask;
    end
    // POKEY registers shadow the bottom of the RAM window, so they never strobe RAM.
    ram_we_d = commit && (mapper == MAP_SG_RAM) && in_ram_win && !pokey_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p2_prev_q <= 1'b0;
      bank_q    <= '0;
      ram_we_q  <= 1'b0;
    end else begin
      p2_prev_q <= p2_prev_d;
      bank_q    <= bank_d;
      ram_we_q  <= ram_we_d;
    end
  end

  assign bank   = bank_q;
  assign ram_we = ram_we_q;

endmodule

// File: rtl/supergame_mapper.sv
// Atari 7800 cartridge mapper: flat and SuperGame ROM banking, optional cart RAM and POKEY window.
// All select/address outputs are combinational; only the bank register and RAM strobe are clocked.
module supergame_mapper
  import cart_pkg::*;
(
  input  logic        sysclk_7_143,
  input  logic        reset,
  input  logic        pclk_2,
  input  logic [15:0] address_in,
  input  logic        rw,
  input  logic [7:0]  din,
  input  logic        dma_read,
  input  logic        cart_cs,
  input  logic [9:0]  cart_flags,
  input  logic [31:0] cart_size,
  output logic [17:0] rom_address,
  output logic        rom_sel,
  output logic        ram_sel,
  output logic        ram_we,
  output logic [13:0] ram_address,
  output logic        pokey_sel,
  output logic [3:0]  bank
);

  supergame_mapper_if bus ();

  assign bus.pclk_2     = pclk_2;
  assign bus.address_in = address_in;
  assign bus.rw         = rw;
  assign bus.din        = din;
  assign bus.dma_read   = dma_read;
  assign bus.cart_cs    = cart_cs;

  mapper_e           mapper;
  logic              pokey_en;
  logic [4:0]        bank_count;
  logic [BANK_W-1:0] bank_mask;
  logic [4:0]        last_bank, second_bank;
  logic [32:0]       flat_sum;
  logic              unused_flags;

  assign unused_flags = ^cart_flags[9:3];

  sg_bank_reg u_bank (
    .clk       (sysclk_7_143),
    .rst       (reset),
    .bus       (bus),
    .mapper    (mapper),
    .pokey_en  (pokey_en),
    .bank_mask (bank_mask),
    .bank      (bank),
    .ram_we    (ram_we)
  );

  always_comb begin
    mapper      = mapper_e'(cart_flags[1:0]);
    pokey_en    = cart_flags[2];
    bank_count  = calc_bank_count(cart_size);
    bank_mask   = calc_bank_mask(bank_count);
    last_bank   = bank_count - 5'd1;
    second_bank = bank_count - 5'd2;
    // Flat images are right-justified against $FFFF; a carry past $10000 means the address is inside the image.
    flat_sum    = {17'b0, address_in} + {1'b0, cart_size};

    rom_address = '0;
    rom_sel     = 1'b0;
    ram_sel     = 1'b0;
    ram_address = '0;
    pokey_sel   = 1'b0;

    if (cart_cs) begin
      case (mapper)
        MAP_SG, MAP_SG_RAM: begin
          if (address_in >= WIN_C000) begin
            rom_sel     = 1'b1;
            rom_address = {last_bank[3:0], address_in[13:0]};
          end else if (address_in >= WIN_8000) begin
            rom_sel     = 1'b1;
            rom_address = {bank, address_in[13:0]};
          end else if (address_in >= WIN_4000) begin
            if (mapper == MAP_SG) begin
              rom_sel     = 1'b1;
              rom_address = {second_bank[3:0], address_in[13:0]};
            end else begin
              ram_sel     = 1'b1;
              ram_address = address_in[13:0];
            end
          end
        end
        default: begin
          rom_sel     = (flat_sum >= 33'h1_0000);
          rom_address = flat_sum[17:0] - 18'h1_0000;
        end
      endcase

      if (pokey_en && (address_in >= WIN_4000) && (address_in < (WIN_4000 + POKEY_SPAN))) begin
        pokey_sel = 1'b1;
        rom_sel   = 1'b0;
        ram_sel   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_supergame_mapper.sv
// Directed bench for supergame_mapper: banking, flat mapping, RAM/POKEY windows,
// write suppression and reset in the middle of a bus write.
module tb_supergame_mapper;

  logic        clk;
  logic        rst;
  logic [9:0]  cart_flags;
  logic [31:0] cart_size;
  logic [17:0] rom_address;
  logic        rom_sel, ram_sel, ram_we, pokey_sel;
  logic [13:0] ram_address;
  logic [3:0]  bank;

  int passed = 0;
  int total  = 0;
  int we_cnt = 0;

  supergame_mapper_if bus ();

  supergame_mapper dut (
    .sysclk_7_143 (clk),
    .reset        (rst),
    .pclk_2       (bus.pclk_2),
    .address_in   (bus.address_in),
    .rw           (bus.rw),
    .din          (bus.din),
    .dma_read     (bus.dma_read),
    .cart_cs      (bus.cart_cs),
    .cart_flags   (cart_flags),
    .cart_size    (cart_size),
    .rom_address  (rom_address),
    .rom_sel      (rom_sel),
    .ram_sel      (ram_sel),
    .ram_we       (ram_we),
    .ram_address  (ram_address),
    .pokey_sel    (pokey_sel),
    .bank         (bank)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ram_we === 1'b1) we_cnt++;

  // driver tasks
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.address_in = a; bus.din = d; bus.rw = 1'b0; bus.cart_cs = 1'b1; bus.pclk_2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.pclk_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.rw = 1'b1;
  endtask

  task automatic cpu_write_phi2_low(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.address_in = a; bus.din = d; bus.rw = 1'b0; bus.cart_cs = 1'b1; bus.pclk_2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic cs);
    bus.address_in = a; bus.rw = 1'b1; bus.cart_cs = cs;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.pclk_2 = 1'b0; bus.address_in = 16'h8000; bus.rw = 1'b1; bus.din = 8'h00;
    bus.dma_read = 1'b0; bus.cart_cs = 1'b0;
    cart_flags = 10'h001; cart_size = 32'h2_0000;
    repeat (3) @(posedge clk); #1;
    total++; if (bank !== 4'h0) $display("FAIL reset_bank: got %h expected 0", bank); else passed++;
    total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b expected 0", ram_we); else passed++;
    total++; if (rom_sel !== 1'b0) $display("FAIL no_cs_rom_sel: got %b expected 0", rom_sel); else passed++;
    total++; if (rom_address !== 18'h0) $display("FAIL no_cs_rom_address: got %h expected 0", rom_address); else passed++;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_sg_bank;
    cart_flags = 10'h001; cart_size = 32'h2_0000;
    cpu_write(16'h8000, 8'h05);
    total++; if (bank !== 4'h5) $display("FAIL sg_bank_load: got %h expected 5", bank); else passed++;
    cpu_read(16'h8123, 1'b1);
    total++; if (rom_address !== 18'h14123) $display("FAIL sg_read_8123: got %h expected 14123", rom_address); else passed++;
    total++; if (rom_sel !== 1'b1) $display("FAIL sg_rom_sel_8123: got %b expected 1", rom_sel); else passed++;
    cpu_read(16'hC000, 1'b1);
    total++; if (rom_address !== 18'h1C000) $display("FAIL sg_read_c000: got %h expected 1c000", rom_address); else passed++;
    cpu_read(16'h4010, 1'b1);
    total++; if (rom_address !== 18'h18010) $display("FAIL sg_read_4010: got %h expected 18010", rom_address); else passed++;
    total++; if (rom_sel !== 1'b1 || ram_sel !== 1'b0) $display("FAIL sg_sel_4010: got rom=%b ram=%b expected rom=1 ram=0", rom_sel, ram_sel); else passed++;
    cpu_read(16'h3FFF, 1'b1);
    total++; if (rom_sel !== 1'b0) $display("FAIL sg_below_4000: got %b expected 0", rom_sel); else passed++;
    cpu_write(16'hC000, 8'h02);
    total++; if (bank !== 4'h5) $display("FAIL sg_write_outside_bank_win: got %h expected 5", bank); else passed++;
    cpu_write(16'h8000, 8'h0F);
    total++; if (bank !== 4'h7) $display("FAIL sg_bank_masked: got %h expected 7", bank); else passed++;
  endtask

  task automatic test_sg_ram;
    cart_flags = 10'h002; cart_size = 32'h2_0000;
    we_cnt = 0;
    cpu_write(16'h4010, 8'hAA);
    total++; if (we_cnt !== 1) $display("FAIL ram_we_pulse: got %0d cycles expected 1", we_cnt); else passed++;
    total++; if (bank !== 4'h7) $display("FAIL ram_write_keeps_bank: got %h expected 7", bank); else passed++;
    cpu_read(16'h4010, 1'b1);
    total++; if (ram_sel !== 1'b1 || rom_sel !== 1'b0) $display("FAIL ram_sel_4010: got ram=%b rom=%b expected ram=1 rom=0", ram_sel, rom_sel); else passed++;
    total++; if (ram_address !== 14'h0010) $display("FAIL ram_address_4010: got %h expected 0010", ram_address); else passed++;
    cpu_read(16'hC000, 1'b1);
    total++; if (rom_address !== 18'h1C000 || ram_sel !== 1'b0) $display("FAIL sgram_read_c000: got %h ram=%b expected 1c000 ram=0", rom_address, ram_sel); else passed++;
  endtask

  task automatic test_suppress;
    cart_flags = 10'h001; cart_size = 32'h2_0000;
    cpu_write(16'h8000, 8'h03);
    total++; if (bank !== 4'h3) $display("FAIL suppress_setup: got %h expected 3", bank); else passed++;
    bus.dma_read = 1'b1;
    cpu_write(16'h8000, 8'h06);
    bus.dma_read = 1'b0;
    total++; if (bank !== 4'h3) $display("FAIL dma_read_write: got %h expected 3", bank); else passed++;
    cpu_write_phi2_low(16'h8000, 8'h06);
    total++; if (bank !== 4'h3) $display("FAIL phi2_low_write: got %h expected 3", bank); else passed++;
    @(posedge clk); #1;
    bus.address_in = 16'h8000; bus.din = 8'h06; bus.rw = 1'b0; bus.cart_cs = 1'b0; bus.pclk_2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.pclk_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.rw = 1'b1;
    total++; if (bank !== 4'h3) $display("FAIL no_cs_write: got %h expected 3", bank); else passed++;
  endtask

  task automatic test_flat;
    cart_flags = 10'h000; cart_size = 32'h0000_C000;
    cpu_read(16'h4000, 1'b1);
    total++; if (rom_address !== 18'h0 || rom_sel !== 1'b1) $display("FAIL flat_4000: got %h sel=%b expected 0 sel=1", rom_address, rom_sel); else passed++;
    cpu_read(16'h3FFF, 1'b1);
    total++; if (rom_sel !== 1'b0) $display("FAIL flat_3fff: got %b expected 0", rom_sel); else passed++;
    cpu_read(16'hFFFF, 1'b1);
    total++; if (rom_address !== 18'h0BFFF) $display("FAIL flat_ffff: got %h expected 0bfff", rom_address); else passed++;
    cpu_write(16'h8000, 8'h01);
    total++; if (bank !== 4'h3) $display("FAIL flat_no_bank_write: got %h expected 3", bank); else passed++;
    cart_flags = 10'h003;
    cpu_read(16'h8000, 1'b1);
    total++; if (rom_address !== 18'h04000 || rom_sel !== 1'b1) $display("FAIL flat_rsvd_8000: got %h sel=%b expected 04000 sel=1", rom_address, rom_sel); else passed++;
    cpu_read(16'h8000, 1'b0);
    total++; if (rom_sel !== 1'b0 || rom_address !== 18'h0) $display("FAIL flat_no_cs: got %h sel=%b expected 0 sel=0", rom_address, rom_sel); else passed++;
  endtask

  task automatic test_bank_sizes;
    cart_flags = 10'h001; cart_size = 32'h0001_4000;
    cpu_write(16'h8000, 8'h07);
    total++; if (bank !== 4'h7) $display("FAIL five_bank_load_past_count: got %h expected 7", bank); else passed++;
    cpu_read(16'h8000, 1'b1);
    total++; if (rom_address !== 18'h1C000) $display("FAIL five_bank_read_8000: got %h expected 1c000", rom_address); else passed++;
    cpu_read(16'hC000, 1'b1);
    total++; if (rom_address !== 18'h10000) $display("FAIL five_bank_read_c000: got %h expected 10000", rom_address); else passed++;
    cart_size = 32'h0010_0000;
    cpu_write(16'h8000, 8'hFF);
    total++; if (bank !== 4'hF) $display("FAIL capped_bank_load: got %h expected f", bank); else passed++;
    cpu_read(16'hC000, 1'b1);
    total++; if (rom_address !== 18'h3C000) $display("FAIL capped_read_c000: got %h expected 3c000", rom_address); else passed++;
    cpu_read(16'h8001, 1'b1);
    total++; if (rom_address !== 18'h3C001) $display("FAIL capped_read_8001: got %h expected 3c001", rom_address); else passed++;
  endtask

  task automatic test_pokey;
    cart_flags = 10'h006; cart_size = 32'h2_0000;
    cpu_read(16'h4005, 1'b1);
    total++; if (pokey_sel !== 1'b1 || ram_sel !== 1'b0 || rom_sel !== 1'b0) $display("FAIL pokey_4005: got pokey=%b ram=%b rom=%b expected 1 0 0", pokey_sel, ram_sel, rom_sel); else passed++;
    cpu_read(16'h4010, 1'b1);
    total++; if (pokey_sel !== 1'b0 || ram_sel !== 1'b1) $display("FAIL pokey_4010: got pokey=%b ram=%b expected 0 1", pokey_sel, ram_sel); else passed++;
    we_cnt = 0;
    cpu_write(16'h4005, 8'h55);
    total++; if (we_cnt !== 0) $display("FAIL pokey_write_no_ram_we: got %0d expected 0", we_cnt); else passed++;
    cpu_read(16'h4005, 1'b0);
    total++; if (pokey_sel !== 1'b0) $display("FAIL pokey_no_cs: got %b expected 0", pokey_sel); else passed++;
  endtask

  task automatic test_reset_mid_write;
    cart_flags = 10'h002; cart_size = 32'h2_0000;
    cpu_write(16'h8000, 8'h04);
    total++; if (bank !== 4'h4) $display("FAIL midreset_setup: got %h expected 4", bank); else passed++;
    we_cnt = 0;
    @(posedge clk); #1;
    bus.address_in = 16'h8000; bus.din = 8'h02; bus.rw = 1'b0; bus.cart_cs = 1'b1; bus.pclk_2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (bank !== 4'h0) $display("FAIL midreset_async_bank: got %h expected 0", bank); else passed++;
    bus.pclk_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.rw = 1'b1;
    total++; if (bank !== 4'h0) $display("FAIL midreset_bank: got %h expected 0", bank); else passed++;
    @(posedge clk); #1;
    bus.address_in = 16'h4020; bus.din = 8'h11; bus.rw = 1'b0; bus.pclk_2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.pclk_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.rw = 1'b1;
    total++; if (we_cnt !== 0) $display("FAIL midreset_ram_we: got %0d expected 0", we_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_sg_bank;
    test_sg_ram;
    test_suppress;
    test_flat;
    test_bank_sizes;
    test_pokey;
    test_reset_mid_write;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/supergame_mapper.md
SUPERGAME_MAPPER -- requirements
Module: supergame_mapper

Interface
REQ-001 SHALL expose: sysclk_7_143  in  1  sole clock (MARIA domain); all state on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: pclk_2  in  1  CPU phi2 level, sampled as data (not a clock).
REQ-004 SHALL expose: address_in  in  16  system address bus AB.
REQ-005 SHALL expose: rw  in  1  bus direction; 1 = read, 0 = write.
REQ-006 SHALL expose: din  in  8  CPU write data bus.
REQ-007 SHALL expose: dma_read  in  1  MARIA owns bus; suppresses all writes.
REQ-008 SHALL expose: cart_cs  in  1  cartridge chip select from system decode.
REQ-009 SHALL expose: cart_flags  in  10  [1:0] mapper (0 flat, 1 SG, 2 SG+RAM, 3 reserved = flat); [2] POKEY at $4000; rest ignored.
REQ-010 SHALL expose: cart_size  in  32  ROM image size in bytes.
REQ-011 SHALL expose: rom_address  out  18  ROM byte address.
REQ-012 SHALL expose: rom_sel  out  1  ROM drives data this access.
REQ-013 SHALL expose: ram_sel, ram_we  out  1 each  cart RAM select, one-cycle write strobe.
REQ-014 SHALL expose: ram_address  out  14  cart RAM byte address.
REQ-015 SHALL expose: pokey_sel  out  1  POKEY register window select.
REQ-016 SHALL expose: bank  out  4  current SG bank register (debug).

Function
REQ-017 SHALL compute bank_count = min(cart_size[21:14], 16); bank_mask = next power of two of bank_count, minus 1.
REQ-018 SHALL detect phi2 fall: p2_fall = p2_prev & ~pclk_2, p2_prev registered each cycle.
REQ-019 SHALL commit a write only when p2_fall & cart_cs & ~rw & ~dma_read.
REQ-020 In SG/SG+RAM, committed write to $8000-$BFFF SHALL load bank <= din[3:0] & bank_mask; new value visible the cycle after commit.
REQ-021 Write with din masked value >= bank_count SHALL still load; read address wraps modulo 2^18.
REQ-022 Flat mode: rom_address = cart_size - ($10000 - address_in), truncated to 18 bits; rom_sel when cart_cs and address_in >= $10000 - cart_size.
REQ-023 SG $C000-$FFFF SHALL map to bank (bank_count-1); $8000-$BFFF to bank register; $4000-$7FFF to bank (bank_count-2) when flags[1:0]=1.
REQ-024 SG+RAM: $4000-$7FFF SHALL assert ram_sel, ram_address = address_in[13:0], rom_sel = 0.
REQ-025 ram_we SHALL pulse exactly one cycle, on the commit cycle, for SG+RAM writes in $4000-$7FFF.
REQ-026 flags[2] set: $4000-$400F SHALL assert pokey_sel and override ram_sel/rom_sel to 0.
REQ-027 rom_address, rom_sel, ram_sel, ram_address, pokey_sel SHALL be combinational from address_in, cart_cs, bank, flags (zero latency).
REQ-028 Without cart_cs, all selects SHALL be 0; rom_address SHALL be 0.
REQ-029 ROM writes outside $8000-$BFFF SHALL be ignored; flat mode SHALL never change bank.
REQ-030 Writes with pclk_2 held low (CPU halted by MARIA) SHALL not commit; no second commit without a new rising phi2.

Reset
REQ-031 Reset SHALL force bank=0, p2_prev=0, ram_we=0 immediately; mid-write, no commit SHALL occur.
REQ-032 First p2_fall after reset release SHALL require a preceding high sample of pclk_2.

Structure
REQ-033 Package cart_pkg SHALL hold the mapper enum, BANK_W=4, window base constants ($4000, $8000, $C000, POKEY span).
REQ-034 One sub-module, sg_bank_reg, SHALL contain edge detect, commit qualification, bank register and ram_we.

Verification
REQ-035 cart_size=128K, SG: write $05 to $8000 -> bank=5; read $8123 -> rom_address=$14123; read $C000 -> $1C000.
REQ-036 SG, read $4010 -> rom_address=$18010; SG+RAM write $AA to $4010 -> ram_we one cycle, ram_address=$0010, rom_sel=0.
REQ-037 Flat, cart_size=48K, read $4000 -> rom_address=$00000, rom_sel=1; read $3FFF -> rom_sel=0.
REQ-038 Write $8000 with dma_read=1, or with pclk_2 held low -> bank unchanged.
REQ-039 flags[2]=1, SG+RAM: access $4005 -> pokey_sel=1, ram_sel=0; $4010 -> ram_sel=1.
REQ-040 Assert reset between phi2 rise and fall of a bank write -> bank=0 after release, no ram_we.
